// File: rtl/ysyx_210184_regfile_sb_if.sv
// Register file bus: write-back, issue, flush and read ports.
// master drives requests; slave is the register file.
interface ysyx_210184_regfile_sb_if #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int RD_PORTS = 2
);
  localparam int AW = $clog2(NREG);

  logic                     w0_ena;
  logic [AW-1:0]            w0_addr;
  logic [XLEN-1:0]          w0_data;
  logic                     w1_ena;
  logic [AW-1:0]            w1_addr;
  logic [XLEN-1:0]          w1_data;
  logic                     issue_ena;
  logic [AW-1:0]            issue_addr;
  logic                     flush;
  logic [RD_PORTS*AW-1:0]   r_addr;
  logic [RD_PORTS*XLEN-1:0] r_data;
  logic [RD_PORTS-1:0]      r_busy;
  logic [NREG-1:0]          busy_vec;

  modport master (
    output w0_ena, w0_addr, w0_data,
    output w1_ena, w1_addr, w1_data,
    output issue_ena, issue_addr, flush,
    output r_addr,
    input  r_data, r_busy, busy_vec
  );

  modport slave (
    input  w0_ena, w0_addr, w0_data,
    input  w1_ena, w1_addr, w1_data,
    input  issue_ena, issue_addr, flush,
    input  r_addr,
    output r_data, r_busy, busy_vec
  );
endinterface

// File: rtl/ysyx_210184_regfile_sb.sv
// Register file, 2 write-back ports, N comb read ports, busy scoreboard.
// Ports: clk, rst_n (async low), bus (slave). Macro REGFILE_BYPASS_EN.
module ysyx_210184_regfile_sb #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int RD_PORTS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ysyx_210184_regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]          r_regs [NREG];
  logic [NREG-1:0]          r_busy;

  logic [NREG-1:0]          w_w0_hit;
  logic [NREG-1:0]          w_w1_hit;
  logic [NREG-1:0]          w_iss_hit;
  logic [RD_PORTS*XLEN-1:0] w_rdata;
  logic [RD_PORTS-1:0]      w_rbusy;

  // Hits only exist for 1..NREG-1, which drops x0 and out-of-range.
  always_comb begin
    w_w0_hit  = '0;
    w_w1_hit  = '0;
    w_iss_hit = '0;
    for (int i = 1; i < NREG; i++) begin
      w_w0_hit[i]  = bus.w0_ena &&
                     (32'(bus.w0_addr) == i);
      w_w1_hit[i]  = bus.w1_ena &&
                     (32'(bus.w1_addr) == i);
      w_iss_hit[i] = bus.issue_ena &&
                     (32'(bus.issue_addr) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_w1_hit[i])
          r_regs[i] <= bus.w1_data;
        else if (w_w0_hit[i])
          r_regs[i] <= bus.w0_data;
        // New producer supersedes a retiring one.
        if (bus.flush)
          r_busy[i] <= 1'b0;
        else if (w_iss_hit[i])
          r_busy[i] <= 1'b1;
        else if (w_w0_hit[i] || w_w1_hit[i])
          r_busy[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    w_rbusy = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      logic [AW-1:0] a;
      a = bus.r_addr[k*AW +: AW];
      if (a != '0 && 32'(a) < NREG) begin
        w_rdata[k*XLEN +: XLEN] = r_regs[a];
        w_rbusy[k] = r_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (bus.w1_ena && bus.w1_addr == a) begin
          w_rdata[k*XLEN +: XLEN] = bus.w1_data;
          w_rbusy[k] = 1'b0;
        end else if (bus.w0_ena && bus.w0_addr == a) begin
          w_rdata[k*XLEN +: XLEN] = bus.w0_data;
          w_rbusy[k] = 1'b0;
        end
`endif
      end
    end
  end

  assign bus.r_data   = w_rdata;
  assign bus.r_busy   = w_rbusy;
  assign bus.busy_vec = r_busy;
endmodule

// File: tb/tb_ysyx_210184_regfile_sb.sv
// Directed vector bench for ysyx_210184_regfile_sb.
// Main DUT NREG=32, second DUT NREG=24 for range checks.
module tb_ysyx_210184_regfile_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_210184_regfile_sb_if #(.XLEN(64), .NREG(32), .RD_PORTS(2)) bus ();
  ysyx_210184_regfile_sb_if #(.XLEN(64), .NREG(24), .RD_PORTS(2)) bus2 ();

  ysyx_210184_regfile_sb #(.XLEN(64), .NREG(32), .RD_PORTS(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  ysyx_210184_regfile_sb #(.XLEN(64), .NREG(24), .RD_PORTS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct {
    logic        w0e;
    logic [4:0]  w0a;
    logic [63:0] w0d;
    logic        w1e;
    logic [4:0]  w1a;
    logic [63:0] w1d;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        b0;
    logic        b1;
    logic [31:0] bv;
  } vec_t;

  vec_t tbl [11];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.w0_ena = 0; bus.w1_ena = 0;
    bus.issue_ena = 0; bus.flush = 0;
    bus2.w0_ena = 0; bus2.w1_ena = 0;
    bus2.issue_ena = 0; bus2.flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1 idle();
    #1;
  endtask

  initial begin
    bus.w0_addr = 0; bus.w0_data = 0;
    bus.w1_addr = 0; bus.w1_data = 0;
    bus.issue_addr = 0; bus.r_addr = 0;
    bus2.w0_addr = 0; bus2.w0_data = 0;
    bus2.w1_addr = 0; bus2.w1_data = 0;
    bus2.issue_addr = 0; bus2.r_addr = 0;
    idle();

    tbl[0]  = '{1,3,'hDEAD,0,0,0,0,0,0,3,0,'hDEAD,0,0,0,0};
    tbl[1]  = '{1,0,'hFFFF,0,0,0,0,0,0,0,3,0,'hDEAD,0,0,0};
    tbl[2]  = '{1,7,'h11,1,7,'h22,0,0,0,7,3,'h22,'hDEAD,0,0,0};
    tbl[3]  = '{0,0,0,0,0,0,1,9,0,9,7,0,'h22,1,0,'h200};
    tbl[4]  = '{0,0,0,1,9,'h55,0,0,0,9,9,'h55,'h55,0,0,0};
    tbl[5]  = '{1,9,'h66,0,0,0,1,9,0,9,3,'h66,'hDEAD,1,0,'h200};
    tbl[6]  = '{0,0,0,0,0,0,1,4,0,4,9,0,'h66,1,1,'h210};
    tbl[7]  = '{0,0,0,0,0,0,1,6,0,6,4,0,0,1,1,'h250};
    tbl[8]  = '{0,0,0,0,0,0,1,8,1,8,6,0,0,0,0,0};
    tbl[9]  = '{0,0,0,0,0,0,1,0,0,0,9,0,'h66,0,0,0};
    tbl[10] = '{1,5,'h1234,0,0,0,0,0,0,5,7,'h1234,'h22,0,0,0};

    repeat (2) @(negedge clk);
    bus.r_addr = {5'd0, 5'd3};
    #1;
    chk("rst_data", bus.r_data[63:0], 0);
    chk("rst_bvec", 64'(bus.busy_vec), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.w0_ena = tbl[i].w0e; bus.w0_addr = tbl[i].w0a;
      bus.w0_data = tbl[i].w0d;
      bus.w1_ena = tbl[i].w1e; bus.w1_addr = tbl[i].w1a;
      bus.w1_data = tbl[i].w1d;
      bus.issue_ena = tbl[i].ie; bus.issue_addr = tbl[i].ia;
      bus.flush = tbl[i].fl;
      bus.r_addr = {tbl[i].ra1, tbl[i].ra0};
      cyc();
      chk($sformatf("v%0d_d0", i), bus.r_data[63:0], tbl[i].d0);
      chk($sformatf("v%0d_d1", i), bus.r_data[127:64], tbl[i].d1);
      chk($sformatf("v%0d_b0", i), 64'(bus.r_busy[0]), 64'(tbl[i].b0));
      chk($sformatf("v%0d_b1", i), 64'(bus.r_busy[1]), 64'(tbl[i].b1));
      chk($sformatf("v%0d_bv", i), 64'(bus.busy_vec), 64'(tbl[i].bv));
    end

    // Same-cycle write vs read of a busy register
    @(negedge clk);
    bus.issue_ena = 1; bus.issue_addr = 2;
    cyc();
    chk("byp_busyset", 64'(bus.busy_vec), 'h4);
    @(negedge clk);
    bus.w0_ena = 1; bus.w0_addr = 2; bus.w0_data = 'hAB;
    bus.r_addr = {5'd0, 5'd2};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_w0_d", bus.r_data[63:0], 'hAB);
    chk("byp_w0_b", 64'(bus.r_busy[0]), 0);
`else
    chk("byp_w0_d", bus.r_data[63:0], 0);
    chk("byp_w0_b", 64'(bus.r_busy[0]), 1);
`endif
    bus.w1_ena = 1; bus.w1_addr = 2; bus.w1_data = 'hCD;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_w1_d", bus.r_data[63:0], 'hCD);
`else
    chk("byp_w1_d", bus.r_data[63:0], 0);
`endif
    cyc();
    chk("byp_after_d", bus.r_data[63:0], 'hCD);
    chk("byp_after_b", 64'(bus.r_busy[0]), 0);

    // Asynchronous reset mid-run
    @(negedge clk);
    bus.issue_ena = 1; bus.issue_addr = 10;
    cyc();
    chk("pre_rst_bv", 64'(bus.busy_vec), 'h400);
    @(negedge clk);
    bus.r_addr = {5'd10, 5'd5};
    #1 chk("pre_rst_d", bus.r_data[63:0], 'h1234);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_d", bus.r_data[63:0], 0);
    chk("mid_rst_b", 64'(bus.r_busy[1]), 0);
    chk("mid_rst_bv", 64'(bus.busy_vec), 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst_d", bus.r_data[63:0], 0);

    // NREG=24: index 26 does not exist
    @(negedge clk);
    bus2.w0_ena = 1; bus2.w0_addr = 26; bus2.w0_data = 'h77;
    bus2.w1_ena = 1; bus2.w1_addr = 23; bus2.w1_data = 'h99;
    bus2.issue_ena = 1; bus2.issue_addr = 26;
    bus2.r_addr = {5'd23, 5'd26};
    cyc();
    chk("n24_x26_d", bus2.r_data[63:0], 0);
    chk("n24_x23_d", bus2.r_data[127:64], 'h99);
    chk("n24_bv", 64'(bus2.busy_vec), 0);
    @(negedge clk);
    bus2.issue_ena = 1; bus2.issue_addr = 23;
    cyc();
    chk("n24_bv23", 64'(bus2.busy_vec), 'h800000);
    chk("n24_b23", 64'(bus2.r_busy[1]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_210184_regfile_sb.md
Name: ysyx_210184_regfile_sb

Overview:
Parametrised integer register file with two write-back ports, N combinational read ports and a per-register busy scoreboard. Issue marks a destination pending; write-back clears it. Sits between decode/issue and the ALU/LSU write-back paths, and lets issue stall on RAW hazards against multi-cycle producers. x0 is hardwired zero and never busy.

Parameters:
XLEN, 64, data width of each register.
NREG, 32, number of architectural registers (2..32); AW = $clog2(NREG) as a localparam.
RD_PORTS, 2, number of read ports; read buses are flattened, port k occupies slice k.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
w0_ena  input  1  write-back port 0 enable (ALU path)
w0_addr  input  AW  write-back port 0 register index
w0_data  input  XLEN  write-back port 0 data
w1_ena  input  1  write-back port 1 enable (LSU path)
w1_addr  input  AW  write-back port 1 register index
w1_data  input  XLEN  write-back port 1 data
issue_ena  input  1  mark issue_addr busy (new producer in flight)
issue_addr  input  AW  destination of issuing instruction
flush  input  1  clear all busy bits (pipeline flush/redirect)
r_addr  input  RD_PORTS*AW  read indices
r_data  output  RD_PORTS*XLEN  read data, combinational
r_busy  output  RD_PORTS  register at r_addr still has a pending producer
busy_vec  output  NREG  raw scoreboard state, bit i = register i busy

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy bits = 0. While rst_n low: r_data = 0, r_busy = 0, busy_vec = 0.
- Register write at posedge: wN_ena & wN_addr != 0 & wN_addr < NREG -> regs[wN_addr] <= wN_data.
- w0 and w1 to the same address in one cycle: w1 wins; w0 data is discarded.
- Writes to x0 or to an index >= NREG are dropped silently.
- Busy bits, next-state per register i (i != 0), in priority order:
  1. flush -> 0 (issue_ena in the same cycle is ignored);
  2. issue_ena & issue_addr == i -> 1, which wins over a same-cycle write-back to i because the new producer supersedes the old;
  3. (w0_ena & w0_addr == i) | (w1_ena & w1_addr == i) -> 0;
  4. otherwise hold.
- busy[0] is constant 0; issue to x0 or to an index >= NREG has no effect.
- Write-back to a register that is not busy still updates data; busy stays 0.
- Read port k, combinational:
  - r_addr == 0 or r_addr >= NREG -> r_data = 0, r_busy = 0;
  - otherwise r_data = regs[r_addr] and r_busy = busy[r_addr], subject to the bypass rules under Optional Feature.
- Latency: a write is visible to reads the cycle after its posedge (0 cycles with bypass). A busy set is visible the cycle after issue.
- Read ports are independent; any number may address the same register.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding, checked in order:
  - w1 match (w1_ena, addr equal, addr != 0) -> r_data = w1_data;
  - else w0 match -> r_data = w0_data;
  - on any match, r_busy = 0, unless issue_ena targets the same address in that cycle, in which case r_busy = busy[addr] & ~match, still 0.
  - flush does not affect r_data.
- Not defined: r_data and r_busy come only from registered state; a write becomes readable, and its busy clear visible, one cycle later.

Test Plan:
- Reset: hold rst_n=0 mid-run after writing x5=0x1234 -> all r_data=0 and busy_vec=0 immediately; after release, read x5 -> 0.
- Basic write/read: w0 x3=0xDEAD, next cycle read x3 on port0 and x0 on port1 -> 0xDEAD and 0. Write x0=0xFFFF -> x0 still reads 0.
- Write collision: w0 x7=0x11 and w1 x7=0x22 in the same cycle -> x7 reads 0x22. Write to index 40 with NREG=32 is not possible (AW=5); with NREG=24, write x26 -> no state change, reads return 0.
- Scoreboard: issue x9 -> busy_vec[9]=1 next cycle, r_busy=1. w1 x9=0x55 -> busy clears, data 0x55. Issue x9 together with w0 x9 in the same cycle -> busy stays 1, data updated.
- Flush: issue x4 and x6, then flush together with issue x8 -> busy_vec all 0, x8 not busy.
- Bypass (REGFILE_BYPASS_EN): x2 busy, w0 x2=0xAB while reading x2 -> same cycle r_data=0xAB, r_busy=0. Without the macro -> old value with r_busy=1, then 0xAB with r_busy=0 next cycle.
